// File: rtl/core_bus_pkg.sv
// rtl/core_bus_pkg.sv - shared types and default regions for the core data-bus router
package core_bus_pkg;

    localparam int MEM_ADDR_W = 39;
    localparam int MEM_DATA_W = 64;
    localparam int MEM_STRB_W = 8;
    localparam int PRV_W      = 2;

    localparam logic [MEM_ADDR_W-1:0] DEF_MMIO_BASE = 39'd0;
    localparam logic [MEM_ADDR_W-1:0] DEF_MMIO_SIZE = 39'd256;
    localparam logic [MEM_ADDR_W-1:0] DEF_MEM_BASE  = 39'h1000;
    localparam logic [MEM_ADDR_W-1:0] DEF_MEM_SIZE  = 39'h10000;

    typedef enum logic [1:0] {
        TGT_MEM  = 2'd0,
        TGT_MMIO = 2'd1,
        TGT_ERR  = 2'd2
    } tgt_e;

    // Single unsigned compare at 40 bits: an address below base wraps to a huge offset.
    function automatic logic in_region(input logic [MEM_ADDR_W-1:0] addr,
                                       input logic [MEM_ADDR_W-1:0] base,
                                       input logic [MEM_ADDR_W-1:0] size);
        logic [MEM_ADDR_W:0] off;
        off = {1'b0, addr} - {1'b0, base};
        return off < {1'b0, size};
    endfunction

endpackage

// File: rtl/core_tag_fifo.sv
// rtl/core_tag_fifo.sv - synchronous tag FIFO with occupancy count and same-cycle push/pop
module core_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic                     g_clk,
    input  logic                     g_resetn,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge g_clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/core_dbus_router.sv
// rtl/core_dbus_router.sv - routes core data-bus requests to memory or counter MMIO, in-order responses
module core_dbus_router
    import core_bus_pkg::*;
#(
    parameter logic [MEM_ADDR_W-1:0] MMIO_BASE       = DEF_MMIO_BASE,
    parameter logic [MEM_ADDR_W-1:0] MMIO_SIZE       = DEF_MMIO_SIZE,
    parameter logic [MEM_ADDR_W-1:0] MEM_BASE        = DEF_MEM_BASE,
    parameter logic [MEM_ADDR_W-1:0] MEM_SIZE        = DEF_MEM_SIZE,
    parameter int                    MAX_OUTSTANDING = 4
) (
    input  logic                  g_clk,
    input  logic                  g_resetn,
    input  logic                  cpu_req_i,
    input  logic                  cpu_wen_i,
    input  logic [MEM_STRB_W-1:0] cpu_strb_i,
    input  logic [MEM_ADDR_W-1:0] cpu_addr_i,
    input  logic [MEM_DATA_W-1:0] cpu_wdata_i,
    input  logic [PRV_W-1:0]      cpu_prv_i,
    output logic                  cpu_gnt_o,
    output logic                  cpu_recv_o,
    output logic [MEM_DATA_W-1:0] cpu_rdata_o,
    output logic                  cpu_error_o,
    output logic                  mem_req_o,
    output logic                  mem_wen_o,
    output logic [MEM_STRB_W-1:0] mem_strb_o,
    output logic [MEM_ADDR_W-1:0] mem_addr_o,
    output logic [MEM_DATA_W-1:0] mem_wdata_o,
    output logic [PRV_W-1:0]      mem_prv_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_recv_i,
    input  logic [MEM_DATA_W-1:0] mem_rdata_i,
    input  logic                  mem_error_i,
    output logic                  mmio_req_o,
    output logic                  mmio_wen_o,
    output logic [MEM_ADDR_W-1:0] mmio_addr_o,
    output logic [MEM_DATA_W-1:0] mmio_wdata_o,
    output logic [PRV_W-1:0]      mmio_prv_o,
    input  logic                  mmio_gnt_i,
    input  logic [MEM_DATA_W-1:0] mmio_rdata_i,
    input  logic                  mmio_error_i
);
    localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

    tgt_e          req_tgt, head_tgt;
    logic [1:0]    head_raw;
    logic          fifo_empty, fifo_full;
    logic [CW-1:0] fifo_count;
    logic          pop, push, mem_ok, solo_ok, ok;
    logic          drain_q, drain_d;

    always_comb begin
        req_tgt = TGT_ERR;
        if (in_region(cpu_addr_i, MMIO_BASE, MMIO_SIZE)) begin
            req_tgt = (cpu_wen_i && cpu_strb_i != '1) ? TGT_ERR : TGT_MMIO;
        end else if (in_region(cpu_addr_i, MEM_BASE, MEM_SIZE)) begin
            req_tgt = TGT_MEM;
        end
    end

    assign head_tgt = tgt_e'(head_raw);

    // MMIO/ERR entries always answer the cycle after accept, so they pop unconditionally.
    assign pop = g_resetn && !fifo_empty && ((head_tgt != TGT_MEM) || mem_recv_i);

    // A non-MEM tag is only ever pushed into an otherwise draining FIFO, so it is always the head.
    assign mem_ok  = (!fifo_full || pop) && (fifo_empty || head_tgt == TGT_MEM);
    assign solo_ok = fifo_empty || (fifo_count == CW'(1) && pop);
    assign ok      = g_resetn && ((req_tgt == TGT_MEM) ? mem_ok : solo_ok);

    assign mem_req_o  = cpu_req_i && (req_tgt == TGT_MEM)  && ok;
    assign mmio_req_o = cpu_req_i && (req_tgt == TGT_MMIO) && ok;
    assign cpu_gnt_o  = (mem_req_o && mem_gnt_i) || (mmio_req_o && mmio_gnt_i)
                      || (cpu_req_i && (req_tgt == TGT_ERR) && ok);
    assign push       = cpu_gnt_o;

    assign mem_wen_o    = cpu_wen_i;
    assign mem_strb_o   = cpu_strb_i;
    assign mem_addr_o   = cpu_addr_i;
    assign mem_wdata_o  = cpu_wdata_i;
    assign mem_prv_o    = cpu_prv_i;
    assign mmio_wen_o   = cpu_wen_i;
    assign mmio_addr_o  = cpu_addr_i;
    assign mmio_wdata_o = cpu_wdata_i;
    assign mmio_prv_o   = cpu_prv_i;

    assign cpu_recv_o = pop;

    always_comb begin
        cpu_rdata_o = '0;
        cpu_error_o = 1'b0;
        if (pop) begin
            case (head_tgt)
                TGT_MEM: begin
                    cpu_rdata_o = mem_rdata_i;
                    cpu_error_o = mem_error_i;
                end
                TGT_MMIO: begin
                    cpu_rdata_o = mmio_rdata_i;
                    cpu_error_o = mmio_error_i;
                end
                default: cpu_error_o = 1'b1;
            endcase
        end
    end

    core_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (2)
    ) u_tag_fifo (
        .g_clk       (g_clk),
        .g_resetn    (g_resetn),
        .push_i      (push),
        .push_data_i (req_tgt),
        .pop_i       (pop),
        .head_o      (head_raw),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full),
        .count_o     (fifo_count)
    );

    // Until the first post-reset accept, stray memory responses are leftovers from before reset.
    always_comb begin
        drain_d = drain_q;
        if (push) drain_d = 1'b0;
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) drain_q <= 1'b1;
        else           drain_q <= drain_d;
    end

    assert property (@(posedge g_clk) disable iff (!g_resetn)
        (mem_recv_i && !drain_q) |-> (!fifo_empty && head_tgt == TGT_MEM));

endmodule

// File: tb/tb_core_dbus_router.sv
// tb/tb_core_dbus_router.sv - self-checking bench for core_dbus_router
module tb_core_dbus_router;
    localparam int T_MEM = 0, T_MMIO = 1, T_ERR = 2;

    logic        g_clk = 1'b0, g_resetn = 1'b0;
    logic        cpu_req, cpu_wen;
    logic [7:0]  cpu_strb;
    logic [38:0] cpu_addr;
    logic [63:0] cpu_wdata;
    logic [1:0]  cpu_prv;
    logic        cpu_gnt, cpu_recv, cpu_error;
    logic [63:0] cpu_rdata;
    logic        mem_req, mem_wen, mem_gnt, mem_recv, mem_error;
    logic [7:0]  mem_strb;
    logic [38:0] mem_addr;
    logic [63:0] mem_wdata, mem_rdata;
    logic [1:0]  mem_prv;
    logic        mmio_req, mmio_wen, mmio_gnt, mmio_error;
    logic [38:0] mmio_addr;
    logic [63:0] mmio_wdata, mmio_rdata;
    logic [1:0]  mmio_prv;

    int n_checks = 0, n_fail = 0;
    int q[$];

    always #5 g_clk = ~g_clk;

    core_dbus_router dut (
        .g_clk(g_clk), .g_resetn(g_resetn),
        .cpu_req_i(cpu_req), .cpu_wen_i(cpu_wen), .cpu_strb_i(cpu_strb), .cpu_addr_i(cpu_addr),
        .cpu_wdata_i(cpu_wdata), .cpu_prv_i(cpu_prv), .cpu_gnt_o(cpu_gnt), .cpu_recv_o(cpu_recv),
        .cpu_rdata_o(cpu_rdata), .cpu_error_o(cpu_error),
        .mem_req_o(mem_req), .mem_wen_o(mem_wen), .mem_strb_o(mem_strb), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_prv_o(mem_prv), .mem_gnt_i(mem_gnt), .mem_recv_i(mem_recv),
        .mem_rdata_i(mem_rdata), .mem_error_i(mem_error),
        .mmio_req_o(mmio_req), .mmio_wen_o(mmio_wen), .mmio_addr_o(mmio_addr),
        .mmio_wdata_o(mmio_wdata), .mmio_prv_o(mmio_prv), .mmio_gnt_i(mmio_gnt),
        .mmio_rdata_i(mmio_rdata), .mmio_error_i(mmio_error)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int decode(input logic [38:0] a, input logic w, input logic [7:0] s);
        longint unsigned ua;
        ua = 64'(a);
        if (ua < 256) return (w && s != 8'hFF) ? T_ERR : T_MMIO;
        if (ua >= 64'h1000 && ua < 64'h11000) return T_MEM;
        return T_ERR;
    endfunction

    // Reference model: outstanding queue of targets, evaluated mid-cycle, then advanced to the next edge.
    always @(negedge g_clk) begin
        int   tgt;
        bit   pop_e, allow, all_mem, gnt_e, mreq_e, ioreq_e, err_e;
        logic [63:0] rd_e;
        tgt = decode(cpu_addr, cpu_wen, cpu_strb);
        pop_e = g_resetn && q.size() > 0 && (q[0] != T_MEM || mem_recv);
        rd_e = '0;
        err_e = 1'b0;
        if (pop_e) begin
            if (q[0] == T_MEM)       begin rd_e = mem_rdata;  err_e = mem_error;  end
            else if (q[0] == T_MMIO) begin rd_e = mmio_rdata; err_e = mmio_error; end
            else                     err_e = 1'b1;
        end
        all_mem = 1'b1;
        foreach (q[i]) if (q[i] != T_MEM) all_mem = 1'b0;
        if (tgt == T_MEM) allow = (q.size() < 4 || pop_e) && all_mem;
        else              allow = q.size() == 0 || (q.size() == 1 && pop_e);
        allow   = allow && g_resetn && cpu_req;
        mreq_e  = allow && tgt == T_MEM;
        ioreq_e = allow && tgt == T_MMIO;
        gnt_e   = (mreq_e && mem_gnt) || (ioreq_e && mmio_gnt) || (allow && tgt == T_ERR);
        chk("m_gnt", cpu_gnt, gnt_e);
        chk("m_mem_req", mem_req, mreq_e);
        chk("m_mmio_req", mmio_req, ioreq_e);
        chk("m_recv", cpu_recv, pop_e);
        chk("m_rdata", cpu_rdata, rd_e);
        chk("m_error", cpu_error, err_e);
        chk("m_mem_addr", mem_addr, cpu_addr);
        chk("m_mmio_addr", mmio_addr, cpu_addr);
        chk("m_wdata", {mem_wdata ^ mmio_wdata}, 64'd0);
        chk("m_mem_wdata", mem_wdata, cpu_wdata);
        chk("m_side", {mem_wen, mem_strb, mem_prv, mmio_wen, mmio_prv},
                      {cpu_wen, cpu_strb, cpu_prv, cpu_wen, cpu_prv});
        if (!g_resetn) q.delete();
        else begin
            if (pop_e) void'(q.pop_front());
            if (gnt_e) q.push_back(tgt);
        end
    end

    task automatic cyc();
        @(posedge g_clk);
        #1;
    endtask

    task automatic idle();
        cpu_req = 0; cpu_wen = 0; cpu_strb = 8'hFF; cpu_addr = '0; cpu_wdata = '0; cpu_prv = 2'b11;
        mem_gnt = 1; mem_recv = 0; mem_rdata = '0; mem_error = 0;
        mmio_gnt = 1; mmio_rdata = '0; mmio_error = 0;
    endtask

    logic [38:0] tab_addr [6] = '{39'hFF, 39'h100, 39'hFFF, 39'h10FF8, 39'h11000, 39'h7F_FFFF_FFFF};
    int          tab_tgt  [6] = '{T_MMIO, T_ERR, T_ERR, T_MEM, T_ERR, T_ERR};

    initial begin
        idle();
        g_resetn = 0;
        cyc(); cyc();
        cpu_req = 1; cpu_addr = 39'h1000; #1;
        chk("rst_gnt", cpu_gnt, 0); chk("rst_mem_req", mem_req, 0); chk("rst_recv", cpu_recv, 0);
        cyc(); idle(); cyc(); g_resetn = 1;

        // memory read, response 3 cycles after grant
        cyc(); cpu_req = 1; cpu_addr = 39'h1000; #1;
        chk("t1_gnt", cpu_gnt, 1); chk("t1_mem_req", mem_req, 1);
        cyc(); idle(); #1; chk("t1_norecv", cpu_recv, 0);
        cyc(); cyc(); mem_recv = 1; mem_rdata = 64'hA5; #1;
        chk("t1_recv", cpu_recv, 1); chk("t1_rdata", cpu_rdata, 64'hA5); chk("t1_err", cpu_error, 0);
        cyc(); idle();

        // MMIO read
        cyc(); cpu_req = 1; cpu_addr = 39'h8; #1;
        chk("t2_mmio_req", mmio_req, 1); chk("t2_mem_req", mem_req, 0); chk("t2_gnt", cpu_gnt, 1);
        cyc(); idle(); mmio_rdata = 64'h1234_5678_9ABC_DEF0; #1;
        chk("t2_recv", cpu_recv, 1); chk("t2_rdata", cpu_rdata, 64'h1234_5678_9ABC_DEF0);
        cyc(); idle();

        // unmapped access
        cyc(); cpu_req = 1; cpu_addr = 39'h800; #1;
        chk("t3_gnt", cpu_gnt, 1); chk("t3_mem_req", mem_req, 0); chk("t3_mmio_req", mmio_req, 0);
        cyc(); idle(); #1;
        chk("t3_recv", cpu_recv, 1); chk("t3_err", cpu_error, 1); chk("t3_rdata", cpu_rdata, 0);
        cyc(); idle();

        // fill the tag FIFO, stall, then grant on the popping cycle
        for (int i = 0; i < 4; i++) begin
            cyc(); cpu_req = 1; cpu_addr = 39'h1000 + 39'(8 * i); #1;
            chk("t4_gnt", cpu_gnt, 1);
        end
        cyc(); cpu_addr = 39'h1020; #1;
        chk("t4_full_gnt", cpu_gnt, 0); chk("t4_full_req", mem_req, 0);
        cyc(); mem_recv = 1; mem_rdata = 64'h11; #1;
        chk("t4_pop_gnt", cpu_gnt, 1); chk("t4_pop_recv", cpu_recv, 1); chk("t4_pop_rdata", cpu_rdata, 64'h11);
        cyc(); idle();
        for (int i = 0; i < 4; i++) begin
            mem_recv = 1; mem_rdata = 64'h20 + 64'(i); #1;
            chk("t4_drain", cpu_recv, 1);
            cyc();
        end
        idle();

        // back-to-back MMIO
        cyc(); cpu_req = 1; cpu_addr = 39'h10; #1; chk("b2b_gnt0", cpu_gnt, 1);
        cyc(); cpu_addr = 39'h18; mmio_rdata = 64'hB1; #1;
        chk("b2b_gnt1", cpu_gnt, 1); chk("b2b_rdata0", cpu_rdata, 64'hB1);
        cyc(); idle(); mmio_rdata = 64'hB2; #1; chk("b2b_rdata1", cpu_rdata, 64'hB2);
        cyc(); idle();

        // MMIO behind MEM, MEM behind MMIO
        cyc(); cpu_req = 1; cpu_addr = 39'h2000; #1; chk("t5_mem_gnt", cpu_gnt, 1);
        cyc(); cpu_addr = 39'h20; #1; chk("t5_stall", cpu_gnt, 0); chk("t5_stall_req", mmio_req, 0);
        cyc(); #1; chk("t5_stall2", cpu_gnt, 0);
        cyc(); mem_recv = 1; mem_rdata = 64'h55; #1;
        chk("t5_recv", cpu_rdata, 64'h55); chk("t5_io_gnt", cpu_gnt, 1); chk("t5_io_req", mmio_req, 1);
        cyc(); idle(); mmio_rdata = 64'h77; cpu_req = 1; cpu_addr = 39'h1000; #1;
        chk("t5_io_rdata", cpu_rdata, 64'h77); chk("t5_mem_blocked", cpu_gnt, 0);
        cyc(); mmio_rdata = 0; #1; chk("t5_mem_gnt2", cpu_gnt, 1);
        cyc(); idle(); mem_recv = 1; mem_rdata = 64'h99; mem_error = 1; #1;
        chk("t5_mem_err", cpu_error, 1); chk("t5_mem_rdata", cpu_rdata, 64'h99);
        cyc(); idle();

        // decode boundaries
        for (int i = 0; i < 6; i++) begin
            cyc(); cpu_req = 1; cpu_addr = tab_addr[i]; #1;
            chk("dec_mem_req", mem_req, 64'(tab_tgt[i] == T_MEM));
            chk("dec_mmio_req", mmio_req, 64'(tab_tgt[i] == T_MMIO));
            chk("dec_gnt", cpu_gnt, 1);
            cyc(); idle();
            if (tab_tgt[i] == T_MEM) begin mem_recv = 1; mem_rdata = 64'(tab_addr[i]); end
            #1;
            chk("dec_recv", cpu_recv, 1); chk("dec_err", cpu_error, 64'(tab_tgt[i] == T_ERR));
            cyc(); idle();
        end

        // partial MMIO write, full MMIO write
        cyc(); cpu_req = 1; cpu_wen = 1; cpu_strb = 8'h0F; cpu_addr = 39'h30; cpu_wdata = 64'hCAFE; #1;
        chk("t6_no_mmio", mmio_req, 0); chk("t6_gnt", cpu_gnt, 1);
        cyc(); idle(); #1;
        chk("t6_recv", cpu_recv, 1); chk("t6_err", cpu_error, 1); chk("t6_rdata", cpu_rdata, 0);
        cyc(); cpu_req = 1; cpu_wen = 1; cpu_strb = 8'hFF; cpu_addr = 39'h30; cpu_wdata = 64'hBEEF; #1;
        chk("t6_full_mmio", mmio_req, 1);
        cyc(); idle(); #1; chk("t6_full_err", cpu_error, 0);
        cyc(); idle();

        // reset with two MEM outstanding, late responses dropped
        cyc(); cpu_req = 1; cpu_addr = 39'h1000; #1; chk("t7_gnt0", cpu_gnt, 1);
        cyc(); cpu_addr = 39'h1008; #1; chk("t7_gnt1", cpu_gnt, 1);
        cyc(); idle(); g_resetn = 0;
        cyc(); cyc(); g_resetn = 1;
        cyc(); mem_recv = 1; mem_rdata = 64'hDEAD; #1;
        chk("t7_late_recv", cpu_recv, 0); chk("t7_late_rdata", cpu_rdata, 0);
        cyc(); #1; chk("t7_late_recv2", cpu_recv, 0);
        cyc(); idle();
        cyc(); cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
